// File: rtl/dmem_ctrl_if.sv
// Request/response bundle types and the bus interface between the dbus decoder and dmem_ctrl.
// dmem_err_o exists only when DMEM_BUSERR_EN is defined.
package dmem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

endpackage

interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  type_dbus2peri_s dbus2dmem_i;
  logic            dmem_sel_i;
  type_peri2dbus_s dmem2dbus_o;

`ifdef DMEM_BUSERR_EN
  logic            dmem_err_o;

  modport master (output dbus2dmem_i, dmem_sel_i, input dmem2dbus_o, dmem_err_o);
  modport slave  (input dbus2dmem_i, dmem_sel_i, output dmem2dbus_o, dmem_err_o);
`else
  modport master (output dbus2dmem_i, dmem_sel_i, input dmem2dbus_o);
  modport slave  (input dbus2dmem_i, dmem_sel_i, output dmem2dbus_o);
`endif

endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory target: word RAM with byte-lane writes, programmable wait states and one-cycle ack.
// Optional feature macro: DMEM_BUSERR_EN (out-of-range accesses are flagged and not serviced).
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q;
  logic [31:0]     r_data_q;

  logic [AW-1:0]   idx_q;
  logic [31:0]     w_data_q;
  logic [3:0]      sel_q;
  logic            w_en_q;
  logic            oor_q;

  logic            req_vld;
  logic            latch_en;
  logic [AW-1:0]   in_idx;
  logic            oor_in;

  logic            commit;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic [3:0]      c_sel;
  logic            c_we;
  logic            c_oor;

  logic [31:0]     mem [DEPTH_WORDS];

  assign req_vld  = bus.dbus2dmem_i.req & bus.dmem_sel_i;
  assign latch_en = (state_q == IDLE) & req_vld;
  assign in_idx   = bus.dbus2dmem_i.addr[AW+1:2];

`ifdef DMEM_BUSERR_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  logic err_q;

  assign oor_in = ({1'b0, bus.dbus2dmem_i.addr} >= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= commit & c_oor;
    end
  end

  assign bus.dmem_err_o = err_q;
`else
  assign oor_in = 1'b0;
`endif

  // With no wait states the commit happens on the accepting edge, so it uses the live request;
  // otherwise it uses the copy latched in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    c_idx   = idx_q;
    c_wdata = w_data_q;
    c_sel   = sel_q;
    c_we    = w_en_q;
    c_oor   = oor_q;
    case (state_q)
      IDLE: begin
        c_idx   = in_idx;
        c_wdata = bus.dbus2dmem_i.w_data;
        c_sel   = bus.dbus2dmem_i.sel_byte;
        c_we    = bus.dbus2dmem_i.w_en;
        c_oor   = oor_in;
        if (req_vld) begin
          cnt_d = WAIT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= commit;
      if (commit) begin
        r_data_q <= (c_we || c_oor) ? 32'h0 : mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      idx_q    <= in_idx;
      w_data_q <= bus.dbus2dmem_i.w_data;
      sel_q    <= bus.dbus2dmem_i.sel_byte;
      w_en_q   <= bus.dbus2dmem_i.w_en;
      oor_q    <= oor_in;
    end
  end

  // RAM array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (c_sel[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dmem2dbus_o.r_data = r_data_q;
  assign bus.dmem2dbus_o.ack    = ack_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (no wait states, three wait states, 16-word depth).
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

`ifdef DMEM_BUSERR_EN
  localparam logic        ERR_EXP    = 1'b1;
  localparam logic [31:0] W0_AFTER   = 32'h01020304;
  localparam logic [31:0] OOR_RD_EXP = 32'h0;
`else
  localparam logic        ERR_EXP    = 1'b0;
  localparam logic [31:0] W0_AFTER   = 32'h99999999;
  localparam logic [31:0] OOR_RD_EXP = 32'h99999999;
`endif

  logic clk;
  logic rst_n;
  type_dbus2peri_s req_s;
  logic [2:0]        sel_v;
  logic [2:0]        ack_w;
  logic [2:0][31:0]  rd_w;
  logic [2:0]        err_w;

  int errors = 0;
  int checks = 0;

  dmem_ctrl_if if0 ();
  dmem_ctrl_if if1 ();
  dmem_ctrl_if if2 ();

  assign if0.dbus2dmem_i = req_s;
  assign if1.dbus2dmem_i = req_s;
  assign if2.dbus2dmem_i = req_s;
  assign if0.dmem_sel_i  = sel_v[0];
  assign if1.dmem_sel_i  = sel_v[1];
  assign if2.dmem_sel_i  = sel_v[2];
  assign ack_w = {if2.dmem2dbus_o.ack, if1.dmem2dbus_o.ack, if0.dmem2dbus_o.ack};
  assign rd_w[0] = if0.dmem2dbus_o.r_data;
  assign rd_w[1] = if1.dmem2dbus_o.r_data;
  assign rd_w[2] = if2.dmem2dbus_o.r_data;
`ifdef DMEM_BUSERR_EN
  assign err_w = {if2.dmem_err_o, if1.dmem_err_o, if0.dmem_err_o};
`else
  assign err_w = 3'b000;
`endif

  dmem_ctrl #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_w0  (.clk(clk), .rst_n(rst_n), .bus(if0));
  dmem_ctrl #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u_w3  (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_ctrl #(.DEPTH_WORDS(16),   .WAIT_CYCLES(0)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sb;
    int          lat;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Call at a negedge; the request is presented in cycle 1 and held through the ack cycle.
  task automatic do_access(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] sb, output int lat, output logic [31:0] rd,
                           output logic er);
    req_s.addr     = a;
    req_s.w_data   = wd;
    req_s.sel_byte = sb;
    req_s.w_en     = we;
    req_s.req      = 1'b1;
    sel_v          = 3'b000;
    sel_v[k]       = 1'b1;
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (ack_w[k]) begin
        lat = c;
        rd  = rd_w[k];
        er  = err_w[k];
        break;
      end
    end
    @(negedge clk);
    chk("single_ack", {31'b0, ack_w[k]}, 32'h0);
    req_s.req = 1'b0;
    sel_v     = 3'b000;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nack;

    tbl[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0};
    tbl[1]  = '{0, 1'b0, 32'h10, 32'h0,        4'hF, 2, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{0, 1'b0, 32'h13, 32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{0, 1'b1, 32'h20, 32'h11223344, 4'hF, 2, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b1, 32'h20, 32'h0000AA00, 4'h2, 2, 32'h0,        1'b0};
    tbl[5]  = '{0, 1'b0, 32'h20, 32'h0,        4'hF, 2, 32'h1122AA44, 1'b0};
    tbl[6]  = '{0, 1'b1, 32'h30, 32'h12345678, 4'hF, 2, 32'h0,        1'b0};
    tbl[7]  = '{0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 2, 32'h0,        1'b0};
    tbl[8]  = '{0, 1'b0, 32'h30, 32'h0,        4'hF, 2, 32'h12345678, 1'b0};
    tbl[9]  = '{0, 1'b1, 32'h30, 32'hAABBCCDD, 4'h9, 2, 32'h0,        1'b0};
    tbl[10] = '{0, 1'b0, 32'h30, 32'h0,        4'hF, 2, 32'hAA3456DD, 1'b0};
    tbl[11] = '{1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 5, 32'h0,        1'b0};
    tbl[12] = '{1, 1'b0, 32'h40, 32'h0,        4'hF, 5, 32'hA5A5A5A5, 1'b0};
    tbl[13] = '{2, 1'b1, 32'h00, 32'h01020304, 4'hF, 2, 32'h0,        1'b0};
    tbl[14] = '{2, 1'b1, 32'h40, 32'h99999999, 4'hF, 2, 32'h0,        ERR_EXP};
    tbl[15] = '{2, 1'b0, 32'h00, 32'h0,        4'hF, 2, W0_AFTER,     1'b0};
    tbl[16] = '{2, 1'b0, 32'h40, 32'h0,        4'hF, 2, OOR_RD_EXP,   ERR_EXP};

    req_s = '0;
    sel_v = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", {31'b0, ack_w[k]}, 32'h0);
      chk("reset_rdata", rd_w[k], 32'h0);
`ifdef DMEM_BUSERR_EN
      chk("reset_err", {31'b0, err_w[k]}, 32'h0);
`endif
    end
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      do_access(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sb, lat, rd, er);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
`ifdef DMEM_BUSERR_EN
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
`endif
    end

    // Abort: store to 0x40 with dmem_sel dropped in the first wait cycle.
    req_s = '{addr: 32'h40, w_data: 32'h55, sel_byte: 4'hF, w_en: 1'b1, req: 1'b1};
    sel_v = 3'b010;
    @(negedge clk);
    sel_v = 3'b000;
    nack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack_w[1]) nack++;
    end
    chk("abort_no_ack", 32'(nack), 32'h0);
    req_s.req = 1'b0;
    do_access(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
    chk("abort_latency", 32'(lat), 32'd5);
    chk("abort_old_value", rd, 32'hA5A5A5A5);

    // Reset asserted while ack is high must clear it without a clock edge.
    req_s = '{addr: 32'h40, w_data: 32'h0, sel_byte: 4'hF, w_en: 1'b0, req: 1'b1};
    sel_v = 3'b010;
    nack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_w[1]) begin
        nack = 1;
        break;
      end
    end
    chk("resp_seen", 32'(nack), 32'h1);
    chk("resp_rdata", rd_w[1], 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", {31'b0, ack_w[1]}, 32'h0);
    chk("async_rst_rdata", rd_w[1], 32'h0);
    req_s.req = 1'b0;
    sel_v = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a store's wait phase drops the store.
    do_access(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
    chk("pre_wait_rst_rdata", rd, 32'hA5A5A5A5);
    req_s = '{addr: 32'h40, w_data: 32'h77777777, sel_byte: 4'hF, w_en: 1'b1, req: 1'b1};
    sel_v = 3'b010;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("wait_rst_ack", {31'b0, ack_w[1]}, 32'h0);
    chk("wait_rst_rdata", rd_w[1], 32'h0);
    req_s.req = 1'b0;
    sel_v = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
    chk("wait_rst_latency", 32'(lat), 32'd5);
    chk("wait_rst_unchanged", rd, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
